// File: rtl/ising_config.sv
// Shared configuration for the LUT programming path: datapath width, GPIO field
// positions and the request/FSM types used by the controller.
package ising_config;

  localparam int num_bits = 16;

  localparam int ADDR_LSB = 0;
  localparam int DATA_LSB = 16;
  localparam int WCLK_BIT = 24;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } lut_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } lut_req_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. Pushes are ignored when full and pops are ignored when empty.
// Reset clears only the pointers and the count; storage keeps stale words.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/lut_program_ctrl.sv
// Queues LUT write requests and plays each one onto the GPIO bus as a setup/strobe/hold
// sequence, suppressing datapath samples while programming is pending or active.
module lut_program_ctrl
  import ising_config::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         wr_addr,
  input  logic [7:0]          wr_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic [31:0]         gpio_out,
  input  logic [num_bits-1:0] dp_val_in,
  input  logic                dp_val_in_valid,
  output logic [num_bits-1:0] dp_val_out,
  output logic                dp_val_out_valid,
  output logic                busy,
  output logic [15:0]         wr_count,
  output logic [15:0]         drop_count
);

  localparam logic [15:0] SETUP_LAST  = 16'(SETUP_CYC - 1);
  localparam logic [15:0] STROBE_LAST = 16'(STROBE_CYC - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYC - 1);

  lut_req_t            head_req;
  logic [23:0]         head_dat;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                hold_done;
  lut_state_e          state_q;
  logic [15:0]         cnt_q;
  logic [31:0]         gpio_q;
  logic [15:0]         wr_count_q;
  logic [15:0]         drop_count_q;
  logic [num_bits-1:0] dp_val_q;
  logic                dp_vld_q;

  sync_fifo #(
    .WIDTH (24),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (wr_valid),
    .push_data_i ({wr_data, wr_addr}),
    .pop_i       (pop),
    .pop_data_o  (head_dat),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign head_req  = lut_req_t'(head_dat);
  // A new request is taken either from idle or straight out of a finished hold.
  assign hold_done = (state_q == HOLD) && (cnt_q == HOLD_LAST);
  assign pop       = !fifo_empty && ((state_q == IDLE) || hold_done);

  assign wr_ready         = !fifo_full;
  assign busy             = (state_q != IDLE) || !fifo_empty;
  assign gpio_out         = gpio_q;
  assign wr_count         = wr_count_q;
  assign drop_count       = drop_count_q;
  assign dp_val_out       = dp_val_q;
  assign dp_val_out_valid = dp_vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gpio_q     <= '0;
      wr_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            gpio_q[ADDR_LSB +: 16] <= head_req.addr;
            gpio_q[DATA_LSB +: 8]  <= head_req.data;
            cnt_q                  <= '0;
            state_q                <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            gpio_q[WCLK_BIT] <= 1'b1;
            cnt_q            <= '0;
            state_q          <= STROBE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        STROBE: begin
          if (cnt_q == STROBE_LAST) begin
            gpio_q[WCLK_BIT] <= 1'b0;
            cnt_q            <= '0;
            state_q          <= HOLD;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        HOLD: begin
          if (hold_done) begin
            wr_count_q <= wr_count_q + 16'd1;
            cnt_q      <= '0;
            if (pop) begin
              gpio_q[ADDR_LSB +: 16] <= head_req.addr;
              gpio_q[DATA_LSB +: 8]  <= head_req.data;
              state_q                <= SETUP;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_val_q     <= '0;
      dp_vld_q     <= 1'b0;
      drop_count_q <= '0;
    end else begin
      dp_val_q <= dp_val_in;
      dp_vld_q <= dp_val_in_valid && !busy;
      if (dp_val_in_valid && busy && (drop_count_q != 16'hFFFF))
        drop_count_q <= drop_count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_lut_program_ctrl.sv
// Bench for lut_program_ctrl: a timeline model predicts, for every request, the edge it
// is popped at and derives w_clk, busy, wr_ready, GPIO contents and counters from that.
module tb_lut_program_ctrl;
  import ising_config::*;

  localparam int S = 2;
  localparam int T = 2;
  localparam int H = 2;
  localparam int P = S + T + H;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst = 1'b1;
  logic [15:0]         wr_addr = '0;
  logic [7:0]          wr_data = '0;
  logic                wr_valid = 1'b0;
  logic                wr_ready;
  logic [31:0]         gpio_out;
  logic [num_bits-1:0] dp_val_in = '0;
  logic                dp_val_in_valid = 1'b0;
  logic [num_bits-1:0] dp_val_out;
  logic                dp_val_out_valid;
  logic                busy;
  logic [15:0]         wr_count;
  logic [15:0]         drop_count;

  logic [15:0]         m_wr_addr = '0;
  logic [7:0]          m_wr_data = '0;
  logic                m_wr_valid = 1'b0;
  logic                m_wr_ready;
  logic [31:0]         m_gpio_out;
  logic [num_bits-1:0] m_dp_val_out;
  logic                m_dp_val_out_valid;
  logic                m_busy_o;
  logic [15:0]         m_wr_count;
  logic [15:0]         m_drop_count;

  lut_program_ctrl dut (
    .clk(clk), .rst(rst), .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .gpio_out(gpio_out), .dp_val_in(dp_val_in),
    .dp_val_in_valid(dp_val_in_valid), .dp_val_out(dp_val_out),
    .dp_val_out_valid(dp_val_out_valid), .busy(busy), .wr_count(wr_count),
    .drop_count(drop_count)
  );

  lut_program_ctrl #(.FIFO_DEPTH(4), .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut_min (
    .clk(clk), .rst(rst), .wr_addr(m_wr_addr), .wr_data(m_wr_data), .wr_valid(m_wr_valid),
    .wr_ready(m_wr_ready), .gpio_out(m_gpio_out), .dp_val_in('0),
    .dp_val_in_valid(1'b0), .dp_val_out(m_dp_val_out),
    .dp_val_out_valid(m_dp_val_out_valid), .busy(m_busy_o), .wr_count(m_wr_count),
    .drop_count(m_drop_count)
  );

  int checks = 0;
  int errors = 0;
  int e_now  = 0;

  int          push_q[$];
  int          start_q[$];
  logic [23:0] req_q[$];
  int          last_start = -1000;

  logic [15:0]         exp_drop = '0;
  logic [num_bits-1:0] exp_dp = '0;
  logic                exp_dp_vld = 1'b0;

  logic [42:0] obs;
  assign obs = {wr_ready, busy, gpio_out[24], gpio_out[23:0], wr_count};

  // Requests sitting in the queue after edge e.
  function automatic int occ(int e);
    int n = 0;
    foreach (push_q[k]) if (push_q[k] <= e && e < start_q[k]) n++;
    return n;
  endfunction

  function automatic logic m_busy(int e);
    foreach (push_q[k]) if (push_q[k] <= e && e < start_q[k] + P) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_wclk(int e);
    foreach (start_q[k]) if (start_q[k] + S <= e && e < start_q[k] + S + T) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [23:0] m_gpio(int e);
    logic [23:0] g = '0;
    foreach (start_q[k]) if (start_q[k] <= e) g = req_q[k];
    return g;
  endfunction

  function automatic logic [15:0] m_wrc(int e);
    int n = 0;
    foreach (start_q[k]) if (start_q[k] + P <= e) n++;
    return 16'(n);
  endfunction

  function automatic logic [42:0] m_obs(int e);
    return {occ(e) < D, m_busy(e), m_wclk(e), m_gpio(e), m_wrc(e)};
  endfunction

  task automatic drive_edge(input logic push, input logic [15:0] a, input logic [7:0] d,
                            input logic vin, input logic [num_bits-1:0] val,
                            output logic accepted);
    logic prev_busy;
    int   st;
    wr_valid = push; wr_addr = a; wr_data = d;
    dp_val_in_valid = vin; dp_val_in = val;
    prev_busy = m_busy(e_now);
    accepted  = push && (occ(e_now) < D);
    @(posedge clk);
    e_now++;
    if (accepted) begin
      st = (e_now + 1 > last_start + P) ? e_now + 1 : last_start + P;
      last_start = st;
      push_q.push_back(e_now);
      start_q.push_back(st);
      req_q.push_back({d, a});
    end
    exp_dp     = val;
    exp_dp_vld = vin && !prev_busy;
    if (vin && prev_busy && exp_drop != 16'hFFFF) exp_drop++;
    @(negedge clk);
    wr_valid = 1'b0;
    dp_val_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_valid = 1'b0; m_wr_valid = 1'b0; dp_val_in_valid = 1'b0; dp_val_in = '0;
    repeat (2) begin @(posedge clk); e_now++; end
    @(negedge clk);
    rst = 1'b0;
    push_q.delete(); start_q.delete(); req_q.delete();
    last_start = -1000;
    exp_drop = '0; exp_dp = '0; exp_dp_vld = 1'b0;
  endtask

  task automatic test_reset();
    logic acc;
    #2;
    checks++;
    if ({gpio_out, dp_val_out, dp_val_out_valid, wr_count, drop_count, wr_ready, busy} !==
        {32'h0, {num_bits{1'b0}}, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got gpio=%h dpo=%h vld=%b wrc=%h drop=%h rdy=%b busy=%b",
               gpio_out, dp_val_out, dp_val_out_valid, wr_count, drop_count, wr_ready, busy);
    end
    checks++;
    if ({m_gpio_out, m_wr_ready, m_busy_o, m_wr_count} !== {32'h0, 1'b1, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_state_min got gpio=%h rdy=%b busy=%b wrc=%h",
               m_gpio_out, m_wr_ready, m_busy_o, m_wr_count);
    end
    do_reset();
    drive_edge(1'b0, 16'h0, 8'h0, 1'b0, '0, acc);
    checks++;
    if (obs !== m_obs(e_now)) begin
      errors++;
      $display("FAIL reset_idle got %h exp %h", obs, m_obs(e_now));
    end
  endtask

  task automatic test_single();
    logic acc;
    int   first_hi = -1;
    int   n_hi = 0;
    drive_edge(1'b1, 16'h0012, 8'hA5, 1'b0, '0, acc);
    checks++;
    if (gpio_out !== 32'h0) begin
      errors++; $display("FAIL single_t0 got %h exp %h", gpio_out, 32'h0);
    end
    for (int k = 1; k <= 9; k++) begin
      drive_edge(1'b0, 16'h0, 8'h0, 1'b0, '0, acc);
      checks++;
      if (obs !== m_obs(e_now)) begin
        errors++; $display("FAIL single_obs k=%0d got %h exp %h", k, obs, m_obs(e_now));
      end
      if (k == 1) begin
        checks++;
        if (gpio_out !== 32'h00A5_0012) begin
          errors++; $display("FAIL single_gpio got %h exp %h", gpio_out, 32'h00A5_0012);
        end
      end
      if (gpio_out[24]) begin
        if (first_hi < 0) first_hi = k;
        n_hi++;
      end
      if (k == 8) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_t8 got %b exp 0", busy); end
      end
    end
    checks++;
    if (first_hi != 3 || n_hi != 2) begin
      errors++; $display("FAIL single_strobe got first=%0d width=%0d exp first=3 width=2", first_hi, n_hi);
    end
    checks++;
    if (wr_count !== 16'd1) begin errors++; $display("FAIL single_wrc got %0d exp 1", wr_count); end
  endtask

  task automatic test_min_timing();
    logic        acc;
    logic [23:0] ra, rb;
    ra = 24'($urandom); rb = 24'($urandom);
    m_wr_valid = 1'b1; m_wr_addr = ra[15:0]; m_wr_data = ra[23:16];
    drive_edge(1'b0, 16'h0, 8'h0, 1'b0, '0, acc);
    m_wr_addr = rb[15:0]; m_wr_data = rb[23:16];
    drive_edge(1'b0, 16'h0, 8'h0, 1'b0, '0, acc);
    m_wr_valid = 1'b0;
    checks++;
    if (m_gpio_out !== {8'h00, ra}) begin
      errors++; $display("FAIL min_first_pop got %h exp %h", m_gpio_out, {8'h00, ra});
    end
    for (int k = 2; k <= 10; k++) begin
      drive_edge(1'b0, 16'h0, 8'h0, 1'b0, '0, acc);
      checks++;
      if (m_gpio_out[24] !== (k == 2 || k == 5)) begin
        errors++; $display("FAIL min_wclk k=%0d got %b exp %b", k, m_gpio_out[24], (k == 2 || k == 5));
      end
      if (k == 5) begin
        checks++;
        if (m_gpio_out[23:0] !== rb) begin
          errors++; $display("FAIL min_second_req got %h exp %h", m_gpio_out[23:0], rb);
        end
      end
    end
    checks++;
    if (m_wr_count !== 16'd2 || m_busy_o !== 1'b0) begin
      errors++; $display("FAIL min_done got wrc=%0d busy=%b exp wrc=2 busy=0", m_wr_count, m_busy_o);
    end
  endtask

  task automatic test_back_to_back();
    logic        acc;
    logic [23:0] reqs[7];
    logic [23:0] seen[$];
    logic        saw_full = 1'b0;
    logic        prev_w = 1'b0;
    int          i = 0;
    int          guard = 0;
    logic [15:0] base;
    base = m_wrc(e_now);
    for (int j = 0; j < 7; j++) reqs[j] = 24'($urandom);
    while ((i < 6 || m_busy(e_now)) && guard < 200) begin
      drive_edge(i < 6, reqs[i][15:0], reqs[i][23:16], 1'b0, '0, acc);
      if (acc) i++;
      checks++;
      if (obs !== m_obs(e_now)) begin
        errors++; $display("FAIL burst_obs e=%0d got %h exp %h", e_now, obs, m_obs(e_now));
      end
      if (!wr_ready) saw_full = 1'b1;
      if (gpio_out[24] && !prev_w) seen.push_back(gpio_out[23:0]);
      prev_w = gpio_out[24];
      guard++;
    end
    checks++;
    if (guard >= 200) begin errors++; $display("FAIL burst_timeout got %0d cycles exp <200", guard); end
    checks++;
    if (!saw_full) begin errors++; $display("FAIL burst_full got ready_low=0 exp 1"); end
    checks++;
    if (seen.size() != 6) begin
      errors++; $display("FAIL burst_count got %0d strobes exp 6", seen.size());
    end else begin
      for (int j = 0; j < 6; j++) begin
        checks++;
        if (seen[j] !== reqs[j]) begin
          errors++; $display("FAIL burst_order idx=%0d got %h exp %h", j, seen[j], reqs[j]);
        end
      end
    end
    checks++;
    if (wr_count !== base + 16'd6) begin
      errors++; $display("FAIL burst_wrc got %0d exp %0d", wr_count, base + 16'd6);
    end
  endtask

  task automatic test_datapath();
    logic        acc;
    logic [15:0] drop_before;
    int          passed = 0;
    int          guard = 0;
    drop_before = exp_drop;
    for (int j = 1; j <= 10; j++) begin
      drive_edge(j == 3, 16'($urandom), 8'($urandom), 1'b1, num_bits'(j), acc);
      checks++;
      if ({dp_val_out_valid, dp_val_out, drop_count} !== {exp_dp_vld, exp_dp, exp_drop}) begin
        errors++; $display("FAIL dp_stream j=%0d got vld=%b val=%h drop=%0d exp vld=%b val=%h drop=%0d",
                           j, dp_val_out_valid, dp_val_out, drop_count, exp_dp_vld, exp_dp, exp_drop);
      end
      if (dp_val_out_valid) passed++;
    end
    while (m_busy(e_now) && guard < 50) begin
      drive_edge(1'b0, 16'h0, 8'h0, 1'b0, '0, acc);
      guard++;
    end
    checks++;
    if (drop_count !== drop_before + 16'd7 || passed != 3) begin
      errors++; $display("FAIL dp_overlap got drop=%0d passed=%0d exp drop=%0d passed=3",
                         drop_count, passed, drop_before + 16'd7);
    end
    for (int c = 0; c < 300; c++) begin
      drive_edge($urandom_range(0, 15) == 0, 16'($urandom), 8'($urandom),
                 1'($urandom_range(0, 1)), num_bits'($urandom), acc);
      checks++;
      if (obs !== m_obs(e_now) || gpio_out[31:25] !== 7'h0) begin
        errors++; $display("FAIL rand_obs c=%0d got %h/%h exp %h/00", c, obs, gpio_out[31:25], m_obs(e_now));
      end
      checks++;
      if ({dp_val_out_valid, dp_val_out, drop_count} !== {exp_dp_vld, exp_dp, exp_drop}) begin
        errors++; $display("FAIL rand_dp c=%0d got vld=%b val=%h drop=%0d exp vld=%b val=%h drop=%0d",
                           c, dp_val_out_valid, dp_val_out, drop_count, exp_dp_vld, exp_dp, exp_drop);
      end
    end
  endtask

  task automatic test_rst_midwrite();
    logic acc;
    int   guard = 0;
    for (int j = 0; j < 3; j++) drive_edge(1'b1, 16'($urandom), 8'($urandom), 1'b0, '0, acc);
    while (!m_wclk(e_now) && guard < 30) begin
      drive_edge(1'b0, 16'h0, 8'h0, 1'b0, '0, acc);
      guard++;
    end
    checks++;
    if (guard >= 30 || gpio_out[24] !== 1'b1) begin
      errors++; $display("FAIL rst_reach_strobe got wclk=%b after %0d cycles exp 1", gpio_out[24], guard);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({gpio_out, wr_ready, busy, wr_count} !== {32'h0, 1'b1, 1'b0, 16'h0}) begin
      errors++; $display("FAIL rst_async got gpio=%h rdy=%b busy=%b wrc=%0d exp 0/1/0/0",
                         gpio_out, wr_ready, busy, wr_count);
    end
    do_reset();
    for (int c = 0; c < 30; c++) begin
      drive_edge(1'b0, 16'h0, 8'h0, 1'b0, '0, acc);
      checks++;
      if (obs !== m_obs(e_now) || gpio_out[24] !== 1'b0) begin
        errors++; $display("FAIL rst_after c=%0d got %h exp %h", c, obs, m_obs(e_now));
      end
    end
  endtask

  task automatic test_drop_saturation();
    do_reset();
    dp_val_in_valid = 1'b1;
    wr_valid = 1'b1; wr_addr = 16'h1234; wr_data = 8'h56;
    @(posedge clk); e_now++;
    @(negedge clk);
    checks++;
    if (drop_count !== 16'd0) begin errors++; $display("FAIL sat_start got %0d exp 0", drop_count); end
    for (int n = 1; n <= 65540; n++) begin
      wr_valid = wr_ready;
      wr_addr  = 16'($urandom);
      @(posedge clk); e_now++;
      @(negedge clk);
      if (n == 100 || n == 65534 || n == 65535 || n == 65540) begin
        checks++;
        if (drop_count !== ((n >= 65535) ? 16'hFFFF : 16'(n))) begin
          errors++; $display("FAIL sat_drop n=%0d got %h exp %h", n, drop_count,
                             ((n >= 65535) ? 16'hFFFF : 16'(n)));
        end
      end
    end
    dp_val_in_valid = 1'b0;
    wr_valid = 1'b0;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_min_timing();
    test_back_to_back();
    test_datapath();
    test_rst_midwrite();
    test_drop_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
